// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: state encodings and default timing.
package sram_port_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF    = 19;
   localparam int unsigned RD_CYCLES_DEF = 2;
   localparam int unsigned WR_CYCLES_DEF = 2;
   localparam int unsigned VID_BURST_DEF = 4;
   localparam int unsigned DATA_W        = 8;
   localparam int unsigned CYC_W         = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4,
      ST_ACK      = 3'd5
   } state_e;

endpackage

// File: rtl/sram_arb_grant.sv
// Video-first priority select with a saturating burst counter that bounds CPU starvation.
// grant_vid/grant_cpu are combinational, one-hot, and only asserted while idle.
module sram_arb_grant
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned VID_BURST = VID_BURST_DEF
) (
   input  logic clk_100,
   input  logic reset_n,
   input  logic idle,
   input  logic cpu_req,
   input  logic vid_req,
   output logic grant_vid,
   output logic grant_cpu
);

   localparam int unsigned CNT_W = $clog2(VID_BURST + 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             cpu_starved;

   always_comb begin
      cpu_starved = cpu_req && (cnt == CNT_W'(VID_BURST));
      grant_vid   = idle && vid_req && !cpu_starved;
      grant_cpu   = idle && cpu_req && !grant_vid;
      cnt_nxt     = cnt;
      // Count video grants only while the CPU is actually waiting.
      if (!cpu_req || grant_cpu) begin
         cnt_nxt = '0;
      end else if (grant_vid && (cnt != CNT_W'(VID_BURST))) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one asynchronous 512Kx8 SRAM between the CPU and video fetch ports,
// sequencing read and setup/pulse/hold write cycles with fully registered pins.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned RD_CYCLES = RD_CYCLES_DEF,
   parameter int unsigned WR_CYCLES = WR_CYCLES_DEF,
   parameter int unsigned VID_BURST = VID_BURST_DEF
) (
   input  logic              clk_100,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              vid_ack,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dout,
   output logic              sram_doe,
   input  logic [DATA_W-1:0] sram_din,
   output logic              sram_we_n
);

   state_e            state;
   state_e            state_nxt;
   logic [CYC_W-1:0]  cyc;
   logic [CYC_W-1:0]  cyc_nxt;
   logic              sel_cpu;
   logic              sel_cpu_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [DATA_W-1:0] dout_nxt;
   logic              doe_nxt;
   logic              we_n_nxt;
   logic              cpu_ack_nxt;
   logic              vid_ack_nxt;
   logic [DATA_W-1:0] cpu_rdata_nxt;
   logic [DATA_W-1:0] vid_rdata_nxt;
   logic              grant_vid;
   logic              grant_cpu;

   sram_arb_grant #(
      .VID_BURST (VID_BURST)
   ) u_grant (
      .clk_100   (clk_100),
      .reset_n   (reset_n),
      .idle      (state == ST_IDLE),
      .cpu_req   (cpu_req),
      .vid_req   (vid_req),
      .grant_vid (grant_vid),
      .grant_cpu (grant_cpu)
   );

   // Next-state and next pin values; every pin is registered below.
   always_comb begin
      state_nxt     = state;
      cyc_nxt       = cyc;
      sel_cpu_nxt   = sel_cpu;
      addr_nxt      = sram_addr;
      dout_nxt      = sram_dout;
      doe_nxt       = 1'b0;
      we_n_nxt      = 1'b1;
      cpu_ack_nxt   = 1'b0;
      vid_ack_nxt   = 1'b0;
      cpu_rdata_nxt = cpu_rdata;
      vid_rdata_nxt = vid_rdata;

      unique case (state)
         ST_IDLE: begin
            if (grant_vid) begin
               sel_cpu_nxt = 1'b0;
               addr_nxt    = vid_addr;
               cyc_nxt     = '0;
               state_nxt   = ST_RD;
            end else if (grant_cpu) begin
               sel_cpu_nxt = 1'b1;
               addr_nxt    = cpu_addr;
               cyc_nxt     = '0;
               if (cpu_we) begin
                  dout_nxt  = cpu_wdata;
                  doe_nxt   = 1'b1;
                  state_nxt = ST_WR_SETUP;
               end else begin
                  state_nxt = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (cyc == CYC_W'(RD_CYCLES - 1)) begin
               if (sel_cpu) begin
                  cpu_rdata_nxt = sram_din;
                  cpu_ack_nxt   = 1'b1;
               end else begin
                  vid_rdata_nxt = sram_din;
                  vid_ack_nxt   = 1'b1;
               end
               state_nxt = ST_ACK;
            end else begin
               cyc_nxt = cyc + CYC_W'(1);
            end
         end
         ST_WR_SETUP: begin
            doe_nxt   = 1'b1;
            we_n_nxt  = 1'b0;
            cyc_nxt   = '0;
            state_nxt = ST_WR_PULSE;
         end
         ST_WR_PULSE: begin
            doe_nxt = 1'b1;
            if (cyc == CYC_W'(WR_CYCLES - 1)) begin
               state_nxt = ST_WR_HOLD;
            end else begin
               we_n_nxt = 1'b0;
               cyc_nxt  = cyc + CYC_W'(1);
            end
         end
         ST_WR_HOLD: begin
            cpu_ack_nxt = sel_cpu;
            vid_ack_nxt = !sel_cpu;
            state_nxt   = ST_ACK;
         end
         ST_ACK: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Pin and handshake registers; reset drops we_n/doe asynchronously mid-cycle.
   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         cyc       <= '0;
         sel_cpu   <= 1'b0;
         sram_addr <= '0;
         sram_dout <= '0;
         sram_doe  <= 1'b0;
         sram_we_n <= 1'b1;
         cpu_ack   <= 1'b0;
         vid_ack   <= 1'b0;
         cpu_rdata <= '0;
         vid_rdata <= '0;
      end else begin
         cyc       <= cyc_nxt;
         sel_cpu   <= sel_cpu_nxt;
         sram_addr <= addr_nxt;
         sram_dout <= dout_nxt;
         sram_doe  <= doe_nxt;
         sram_we_n <= we_n_nxt;
         cpu_ack   <= cpu_ack_nxt;
         vid_ack   <= vid_ack_nxt;
         cpu_rdata <= cpu_rdata_nxt;
         vid_rdata <= vid_rdata_nxt;
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small behavioural SRAM on the pins.
module tb_sram_port_arbiter;
   import sram_port_arbiter_pkg::*;

   localparam int unsigned AW = ADDR_W_DEF;

   logic          clk_100 = 1'b0;
   logic          reset_n = 1'b0;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_wdata = '0;
   logic [7:0]    cpu_rdata;
   logic          cpu_ack;
   logic          vid_req = 1'b0;
   logic [AW-1:0] vid_addr = '0;
   logic [7:0]    vid_rdata;
   logic          vid_ack;
   logic [AW-1:0] sram_addr;
   logic [7:0]    sram_dout;
   logic          sram_doe;
   logic [7:0]    sram_din;
   logic          sram_we_n;

   logic [7:0]    mem [0:1023];
   int            n_cmp = 0;
   int            n_fail = 0;

   // Per-cycle expectations after the request edge (bit n = cycle n).
   logic [1:6] wr_we_n = 6'b100111;
   logic [1:6] wr_doe  = 6'b111100;
   logic [1:6] wr_ack  = 6'b000010;
   logic [1:4] rd_ack  = 4'b0010;
   logic [1:9] sim_vid = 9'b001000000;
   logic [1:9] sim_cpu = 9'b000000100;
   logic [0:9] burst_pat = 10'b0000100001;

   sram_port_arbiter #(
      .ADDR_W    (ADDR_W_DEF),
      .RD_CYCLES (RD_CYCLES_DEF),
      .WR_CYCLES (WR_CYCLES_DEF),
      .VID_BURST (VID_BURST_DEF)
   ) dut (
      .clk_100   (clk_100),
      .reset_n   (reset_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .vid_req   (vid_req),
      .vid_addr  (vid_addr),
      .vid_rdata (vid_rdata),
      .vid_ack   (vid_ack),
      .sram_addr (sram_addr),
      .sram_dout (sram_dout),
      .sram_doe  (sram_doe),
      .sram_din  (sram_din),
      .sram_we_n (sram_we_n)
   );

   always #5 clk_100 = ~clk_100;

   // Asynchronous SRAM: combinational read, write captured on the WE_n rising edge.
   assign sram_din = mem[sram_addr[9:0]];
   always @(posedge sram_we_n) begin
      if (sram_doe === 1'b1) mem[sram_addr[9:0]] <= sram_dout;
   end

   task automatic tick();
      @(posedge clk_100);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk_100);
      #1;
      n_cmp++;
      if ({sram_we_n, sram_doe, cpu_ack, vid_ack} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b expected 1000", {sram_we_n, sram_doe, cpu_ack, vid_ack});
      end
      n_cmp++;
      if ({sram_addr, sram_dout, cpu_rdata, vid_rdata} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h dout=%h crd=%h vrd=%h expected all 0",
                  sram_addr, sram_dout, cpu_rdata, vid_rdata);
      end
      #3 reset_n = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         n_cmp++;
         if ({sram_we_n, sram_doe, cpu_ack, vid_ack, sram_addr} !== {4'b1000, 19'h0}) begin
            n_fail++;
            $display("FAIL idle n=%0d: got we_n/doe/cack/vack=%b addr=%h expected 1000 addr=0",
                     n, {sram_we_n, sram_doe, cpu_ack, vid_ack}, sram_addr);
         end
      end
   endtask

   task automatic test_cpu_write();
      logic [3:0] exp;
      cpu_we    = 1'b1;
      cpu_addr  = 19'h12345;
      cpu_wdata = 8'hA5;
      cpu_req   = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         tick();
         exp = {wr_we_n[n], wr_doe[n], wr_ack[n], 1'b0};
         n_cmp++;
         if ({sram_we_n, sram_doe, cpu_ack, vid_ack} !== exp) begin
            n_fail++;
            $display("FAIL wr_pins n=%0d: got %b expected %b", n,
                     {sram_we_n, sram_doe, cpu_ack, vid_ack}, exp);
         end
         if (n <= 4) begin
            n_cmp++;
            if ({sram_addr, sram_dout} !== {19'h12345, 8'hA5}) begin
               n_fail++;
               $display("FAIL wr_bus n=%0d: got addr=%h dout=%h expected 12345/a5",
                        n, sram_addr, sram_dout);
            end
         end
         if (n == 5) cpu_req = 1'b0;
      end
      cpu_we = 1'b0;
      n_cmp++;
      if (mem[10'h345] !== 8'hA5) begin
         n_fail++;
         $display("FAIL wr_mem: got %h expected a5", mem[10'h345]);
      end
   endtask

   task automatic test_cpu_read();
      cpu_we   = 1'b0;
      cpu_addr = 19'h12345;
      cpu_req  = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         n_cmp++;
         if ({sram_we_n, sram_doe, cpu_ack, vid_ack} !== {2'b10, rd_ack[n], 1'b0}) begin
            n_fail++;
            $display("FAIL rd_pins n=%0d: got %b expected %b", n,
                     {sram_we_n, sram_doe, cpu_ack, vid_ack}, {2'b10, rd_ack[n], 1'b0});
         end
         if (n >= 3) begin
            n_cmp++;
            if ({cpu_rdata, vid_rdata} !== {8'hA5, 8'h00}) begin
               n_fail++;
               $display("FAIL rd_data n=%0d: got cpu=%h vid=%h expected a5/00",
                        n, cpu_rdata, vid_rdata);
            end
         end
         if (n == 3) cpu_req = 1'b0;
      end
   endtask

   task automatic test_burst_limit();
      logic [0:9] got = '0;
      int         acks = 0;
      int         first_ack = 0;
      cpu_we   = 1'b0;
      cpu_addr = 19'h00010;
      vid_addr = 19'h00200;
      cpu_req  = 1'b1;
      vid_req  = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         tick();
         if (cpu_ack || vid_ack) begin
            if (acks == 0) first_ack = n;
            if (acks < 10) got[acks] = cpu_ack;
            acks++;
            n_cmp++;
            if (cpu_ack && vid_ack) begin
               n_fail++;
               $display("FAIL burst_onehot n=%0d: got both acks expected one", n);
            end
            n_cmp++;
            if (cpu_ack ? (cpu_rdata !== 8'h4A) : (vid_rdata !== 8'h5A)) begin
               n_fail++;
               $display("FAIL burst_data n=%0d: got cpu=%h vid=%h expected 4a/5a",
                        n, cpu_rdata, vid_rdata);
            end
         end
         if (n == 40) begin
            cpu_req = 1'b0;
            vid_req = 1'b0;
         end
      end
      n_cmp++;
      if (acks != 10 || first_ack != 3) begin
         n_fail++;
         $display("FAIL burst_count: got acks=%0d first=%0d expected 10/3", acks, first_ack);
      end
      n_cmp++;
      if (got !== burst_pat) begin
         n_fail++;
         $display("FAIL burst_order: got %b expected %b (1=cpu)", got, burst_pat);
      end
      repeat (2) tick();
   endtask

   task automatic test_simultaneous();
      cpu_we   = 1'b0;
      cpu_addr = 19'h00020;
      vid_addr = 19'h00301;
      cpu_req  = 1'b1;
      vid_req  = 1'b1;
      for (int n = 1; n <= 9; n++) begin
         tick();
         n_cmp++;
         if ({cpu_ack, vid_ack} !== {sim_cpu[n], sim_vid[n]}) begin
            n_fail++;
            $display("FAIL sim_acks n=%0d: got %b expected %b", n,
                     {cpu_ack, vid_ack}, {sim_cpu[n], sim_vid[n]});
         end
         if (n == 1) begin
            n_cmp++;
            if (sram_addr !== 19'h00301) begin
               n_fail++;
               $display("FAIL sim_first: got addr=%h expected 00301", sram_addr);
            end
         end
         if (n == 3) begin
            vid_req = 1'b0;
            n_cmp++;
            if (vid_rdata !== 8'h5B) begin
               n_fail++;
               $display("FAIL sim_vdata: got %h expected 5b", vid_rdata);
            end
         end
         if (n == 7) begin
            cpu_req = 1'b0;
            n_cmp++;
            if (cpu_rdata !== 8'h7A) begin
               n_fail++;
               $display("FAIL sim_cdata: got %h expected 7a", cpu_rdata);
            end
         end
      end
   endtask

   task automatic test_reset_mid_write();
      cpu_we    = 1'b1;
      cpu_addr  = 19'h00040;
      cpu_wdata = 8'h3C;
      cpu_req   = 1'b1;
      repeat (2) tick();
      n_cmp++;
      if ({sram_we_n, sram_doe} !== 2'b01) begin
         n_fail++;
         $display("FAIL mid_pulse: got we_n/doe=%b expected 01", {sram_we_n, sram_doe});
      end
      #2;
      reset_n = 1'b0;
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      #1;
      n_cmp++;
      if ({sram_we_n, sram_doe, sram_addr} !== {2'b10, 19'h0}) begin
         n_fail++;
         $display("FAIL mid_async: got we_n/doe=%b addr=%h expected 10 addr=0",
                  {sram_we_n, sram_doe}, sram_addr);
      end
      tick();
      #3 reset_n = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         tick();
         n_cmp++;
         if ({sram_we_n, sram_doe, cpu_ack, vid_ack} !== 4'b1000) begin
            n_fail++;
            $display("FAIL post_reset n=%0d: got %b expected 1000", n,
                     {sram_we_n, sram_doe, cpu_ack, vid_ack});
         end
      end
      // A fresh read must see normal IDLE latency.
      cpu_addr = 19'h12345;
      cpu_req  = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         tick();
         n_cmp++;
         if (cpu_ack !== rd_ack[n]) begin
            n_fail++;
            $display("FAIL post_read n=%0d: got ack=%b expected %b", n, cpu_ack, rd_ack[n]);
         end
         if (n == 3) begin
            cpu_req = 1'b0;
            n_cmp++;
            if (cpu_rdata !== 8'hA5) begin
               n_fail++;
               $display("FAIL post_rdata: got %h expected a5", cpu_rdata);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_burst_limit();
      test_simultaneous();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
